// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and small helpers for the LCD text feeder.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;

  localparam logic [7:0] CHR_NL = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_COLLECT,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE
  } lcd_state_t;

  // A newline on line 1 moves to line 2; a newline on line 2 wraps to line 1.
  function automatic logic [7:0] line_cmd(input logic [4:0] cur);
    return (cur < 5'd16) ? LCD_CMD_LINE2 : LCD_CMD_LINE1;
  endfunction

  function automatic logic [31:0] cmd_word(input logic [7:0] cmd);
    return {cmd, 24'h000000};
  endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Byte FIFO with show-ahead read data; DEPTH must be a power of two.
module lcd_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_feeder.sv
// Streams ASCII text into 32-bit LCD driver transfers, tracking the cursor on a 2x16 display.
//   state          | meaning
//   ST_INIT        | load the power-on clear command
//   ST_COLLECT     | pop bytes into the word buffer, decode newline / clear
//   ST_ISSUE       | wait for LCD_Available, then strobe enableWriting
//   ST_WAIT_ACCEPT | wait for the driver to drop LCD_Available
//   ST_WAIT_DONE   | wait for LCD_Available, update cursor, issue any queued command
module lcd_text_feeder
  import lcd_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         FLUSH_CYCLES = 50000,
  parameter logic [7:0] PAD_CHAR     = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_char,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        LCD_Available,
  output logic [31:0] data,
  output logic        selectCD,
  output logic        enableWriting,
  output logic [4:0]  cursor,
  output logic        busy
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_TC = FW'(FLUSH_CYCLES);
  localparam logic [31:0] PAD_WORD = {4{PAD_CHAR}};

  lcd_state_t    state;
  lcd_state_t    state_next;
  logic          en_next;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [31:0]   word_buf;
  logic [31:0]   slot_buf;
  logic [1:0]    byte_cnt;
  logic [FW-1:0] flush_cnt;
  logic          flush_fire;
  logic          pend_valid;
  logic [7:0]    pend_cmd;
  logic          is_nl;
  logic          is_ff;
  logic          is_chr;
  logic [4:0]    cursor_adv;
  logic          auto_valid;
  logic [7:0]    auto_cmd;
  logic          next_pend_valid;
  logic [7:0]    next_pend_cmd;

  lcd_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_char),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = !fifo_empty || (byte_cnt != 2'd0) || pend_valid || (state != ST_COLLECT);

  assign is_nl  = (fifo_dout == CHR_NL);
  assign is_ff  = (fifo_dout == CHR_FF);
  assign is_chr = !is_nl && !is_ff;

  assign flush_fire = (state == ST_COLLECT) && fifo_empty && (byte_cnt != 2'd0)
                      && (flush_cnt == FLUSH_TC);

  // Word completion at the end of a line queues the matching address command.
  assign cursor_adv      = cursor + 5'd4;
  assign auto_valid      = selectCD && ((cursor_adv == 5'd16) || (cursor_adv == 5'd0));
  assign auto_cmd        = (cursor_adv == 5'd0) ? LCD_CMD_LINE1 : LCD_CMD_LINE2;
  assign next_pend_valid = pend_valid || auto_valid;
  assign next_pend_cmd   = auto_valid ? auto_cmd : pend_cmd;

  always_comb begin
    slot_buf = word_buf;
    case (byte_cnt)
      2'd0:    slot_buf[31:24] = fifo_dout;
      2'd1:    slot_buf[23:16] = fifo_dout;
      2'd2:    slot_buf[15:8]  = fifo_dout;
      default: slot_buf[7:0]   = fifo_dout;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_INIT;
      enableWriting <= 1'b0;
    end else begin
      state         <= state_next;
      enableWriting <= en_next;
    end
  end

  always_comb begin
    state_next = state;
    en_next    = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      ST_INIT: state_next = ST_ISSUE;
      ST_COLLECT: begin
        fifo_pop = !fifo_empty;
        if (fifo_pop && (!is_chr || (byte_cnt == 2'd3))) state_next = ST_ISSUE;
        else if (flush_fire)                             state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (LCD_Available) begin
          en_next    = 1'b1;
          state_next = ST_WAIT_ACCEPT;
        end
      end
      ST_WAIT_ACCEPT: if (!LCD_Available) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (LCD_Available) state_next = next_pend_valid ? ST_ISSUE : ST_COLLECT;
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      selectCD   <= 1'b1;
      cursor     <= '0;
      word_buf   <= PAD_WORD;
      byte_cnt   <= '0;
      flush_cnt  <= '0;
      pend_valid <= 1'b0;
      pend_cmd   <= '0;
    end else begin
      if ((state == ST_COLLECT) && !fifo_pop && (byte_cnt != 2'd0) && !flush_fire)
        flush_cnt <= flush_cnt + 1'b1;
      else
        flush_cnt <= '0;

      case (state)
        ST_INIT: begin
          data     <= cmd_word(LCD_CMD_CLEAR);
          selectCD <= 1'b0;
        end
        ST_COLLECT: begin
          if (fifo_pop) begin
            if (is_ff) begin
              word_buf <= PAD_WORD;
              byte_cnt <= '0;
              data     <= cmd_word(LCD_CMD_CLEAR);
              selectCD <= 1'b0;
            end else if (is_nl) begin
              word_buf <= PAD_WORD;
              byte_cnt <= '0;
              if (byte_cnt != 2'd0) begin
                data       <= word_buf;
                selectCD   <= 1'b1;
                pend_valid <= 1'b1;
                pend_cmd   <= line_cmd(cursor);
              end else begin
                data     <= cmd_word(line_cmd(cursor));
                selectCD <= 1'b0;
              end
            end else if (byte_cnt == 2'd3) begin
              data     <= slot_buf;
              selectCD <= 1'b1;
              word_buf <= PAD_WORD;
              byte_cnt <= '0;
            end else begin
              word_buf <= slot_buf;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (flush_fire) begin
            data     <= word_buf;
            selectCD <= 1'b1;
            word_buf <= PAD_WORD;
            byte_cnt <= '0;
          end
        end
        ST_WAIT_DONE: begin
          if (LCD_Available) begin
            if (selectCD) cursor <= cursor_adv;
            else          cursor <= (data[31:24] == LCD_CMD_LINE2) ? 5'd16 : 5'd0;
            if (next_pend_valid) begin
              data       <= cmd_word(next_pend_cmd);
              selectCD   <= 1'b0;
              pend_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Randomized self-checking bench for lcd_text_feeder against a text-level model of the display stream.
module tb_lcd_text_feeder;
  import lcd_pkg::*;

  localparam int FLUSH = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        LCD_Available;
  logic [31:0] data;
  logic        selectCD;
  logic        enableWriting;
  logic [4:0]  cursor;
  logic        busy;

  always #5 clk = ~clk;

  lcd_text_feeder #(.FIFO_DEPTH(16), .FLUSH_CYCLES(FLUSH), .PAD_CHAR(8'h20)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_char       (in_char),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .LCD_Available (LCD_Available),
    .data          (data),
    .selectCD      (selectCD),
    .enableWriting (enableWriting),
    .cursor        (cursor),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Driver model: captures each strobe, goes unavailable for 3 cycles; hold forces it unavailable.
  logic        drv_avail = 1'b1;
  logic        hold = 1'b0;
  int          drv_cnt = 0;
  longint      cyc = 0;
  longint      last_cap_cyc = 0;
  logic [32:0] got_q[$];

  assign LCD_Available = drv_avail && !hold;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (enableWriting) begin
      got_q.push_back({selectCD, data});
      last_cap_cyc <= cyc;
      drv_avail    <= 1'b0;
      drv_cnt      <= 3;
    end else if (drv_cnt > 0) begin
      drv_cnt <= drv_cnt - 1;
      if (drv_cnt == 1) drv_avail <= 1'b1;
    end
  end

  // Reference model: text stream -> expected transfers and cursor position.
  logic [32:0] exp_q[$];
  logic [7:0]  m_buf[$];
  int          m_cur = 0;

  function automatic void m_cmd(input logic [7:0] c);
    exp_q.push_back({1'b0, c, 24'h000000});
    m_cur = (c == 8'hC0) ? 16 : 0;
  endfunction

  function automatic void m_word(input bit with_auto);
    logic [31:0] w;
    w = 32'h20202020;
    for (int i = 0; i < m_buf.size(); i++) w[31 - 8*i -: 8] = m_buf[i];
    exp_q.push_back({1'b1, w});
    m_buf.delete();
    m_cur = m_cur + 4;
    if (with_auto && m_cur == 16) m_cmd(8'hC0);
    else if (with_auto && m_cur == 32) m_cmd(8'h80);
  endfunction

  function automatic void m_push(input logic [7:0] c);
    logic [7:0] lc;
    if (c == 8'h0C) begin
      m_buf.delete();
      m_cmd(8'h01);
    end else if (c == 8'h0A) begin
      lc = (m_cur < 16) ? 8'hC0 : 8'h80;
      if (m_buf.size() > 0) m_word(1'b0);
      m_cmd(lc);
    end else begin
      m_buf.push_back(c);
      if (m_buf.size() == 4) m_word(1'b1);
    end
  endfunction

  function automatic void m_flush();
    if (m_buf.size() > 0) m_word(1'b1);
  endfunction

  task automatic push_char(input logic [7:0] c, output bit ok);
    int g;
    g = 0;
    @(negedge clk);
    in_char  = c;
    in_valid = 1'b1;
    while (!in_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    ok = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (ok) m_push(c);
  endtask

  task automatic wait_idle(output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic next_pair(output logic [32:0] g, output logic [32:0] e);
    g = got_q.pop_front();
    e = exp_q.pop_front();
  endtask

  task automatic push_string(input string s, output bit ok);
    bit k;
    ok = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      push_char(s[i], k);
      ok = ok && k;
    end
  endtask

  task automatic test_reset();
    bit ok;
    logic [32:0] g, e;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", data); else n_pass++;
    n_checks++; if (selectCD !== 1'b1) $display("FAIL reset_selectCD: got %b want 1", selectCD); else n_pass++;
    n_checks++; if (enableWriting !== 1'b0) $display("FAIL reset_enable: got %b want 0", enableWriting); else n_pass++;
    n_checks++; if (cursor !== 5'd0) $display("FAIL reset_cursor: got %0d want 0", cursor); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
    rst = 1'b0;
    m_cmd(8'h01);
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL reset_idle_timeout: got busy want idle"); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL reset_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      next_pair(g, e);
      n_checks++; if (g !== e) $display("FAIL reset_clear_xfer: got cd=%b data=%h want cd=%b data=%h", g[32], g[31:0], e[32], e[31:0]); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
    n_checks++; if (cursor !== 5'(m_cur)) $display("FAIL reset_cursor_after: got %0d want %0d", cursor, m_cur); else n_pass++;
  endtask

  task automatic test_hello();
    bit ok, ok2;
    logic [32:0] g, e;
    push_string("HELLO WORLD!", ok);
    wait_idle(ok2);
    n_checks++; if (!(ok && ok2)) $display("FAIL hello_timeout: got stalled want idle"); else n_pass++;
    m_flush();
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL hello_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      next_pair(g, e);
      n_checks++; if (g !== e) $display("FAIL hello_xfer: got cd=%b data=%h want cd=%b data=%h", g[32], g[31:0], e[32], e[31:0]); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
    n_checks++; if (cursor !== 5'(m_cur)) $display("FAIL hello_cursor: got %0d want %0d", cursor, m_cur); else n_pass++;
  endtask

  task automatic test_line_wrap();
    bit ok, k;
    logic [32:0] g, e;
    push_char(8'h0C, ok);
    for (int half = 0; half < 2; half++) begin
      for (int i = 0; i < 16; i++) begin
        push_char(8'($urandom_range(8'h21, 8'h7E)), k);
        ok = ok && k;
      end
      wait_idle(k);
      n_checks++; if (!(ok && k)) $display("FAIL wrap_timeout: got stalled want idle"); else n_pass++;
      m_flush();
      n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        next_pair(g, e);
        n_checks++; if (g !== e) $display("FAIL wrap_xfer: got cd=%b data=%h want cd=%b data=%h", g[32], g[31:0], e[32], e[31:0]); else n_pass++;
      end
      got_q.delete(); exp_q.delete();
      n_checks++; if (cursor !== 5'(m_cur)) $display("FAIL wrap_cursor: got %0d want %0d", cursor, m_cur); else n_pass++;
    end
  endtask

  task automatic test_newline();
    bit ok, k;
    logic [32:0] g, e;
    push_char(8'h0C, ok);
    push_string("AB", k); ok = ok && k;
    push_char(8'h0A, k); ok = ok && k;
    push_char(8'h0A, k); ok = ok && k;
    wait_idle(k);
    n_checks++; if (!(ok && k)) $display("FAIL newline_timeout: got stalled want idle"); else n_pass++;
    m_flush();
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL newline_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      next_pair(g, e);
      n_checks++; if (g !== e) $display("FAIL newline_xfer: got cd=%b data=%h want cd=%b data=%h", g[32], g[31:0], e[32], e[31:0]); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
    n_checks++; if (cursor !== 5'(m_cur)) $display("FAIL newline_cursor: got %0d want %0d", cursor, m_cur); else n_pass++;
  endtask

  task automatic test_flush();
    bit ok;
    longint t0, dt;
    logic [32:0] g, e;
    push_char(8'h58, ok);
    t0 = cyc;
    for (int i = 0; i < 200 && got_q.size() == 0; i++) @(negedge clk);
    dt = last_cap_cyc - t0;
    n_checks++; if (!ok || got_q.size() == 0) $display("FAIL flush_timeout: got no transfer want padded word"); else n_pass++;
    n_checks++; if (dt < FLUSH || dt > FLUSH + 12) $display("FAIL flush_latency: got %0d cycles want %0d..%0d", dt, FLUSH, FLUSH + 12); else n_pass++;
    wait_idle(ok);
    m_flush();
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL flush_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      next_pair(g, e);
      n_checks++; if (g !== e) $display("FAIL flush_xfer: got cd=%b data=%h want cd=%b data=%h", g[32], g[31:0], e[32], e[31:0]); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok, k;
    logic [32:0] g, e;
    hold = 1'b1;
    push_char(8'h0C, ok);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_15: got %b want 1", in_ready); else n_pass++;
      end
      push_char(8'($urandom_range(8'h30, 8'h5A)), k);
      ok = ok && k;
    end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_16: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (got_q.size() != 0) $display("FAIL bp_held_xfer: got %0d transfers want 0", got_q.size()); else n_pass++;
    fork
      begin
        repeat (200) @(negedge clk);
        hold = 1'b0;
      end
    join_none
    for (int i = 0; i < 4; i++) begin
      push_char(8'($urandom_range(8'h30, 8'h5A)), k);
      ok = ok && k;
    end
    wait_idle(k);
    n_checks++; if (!(ok && k)) $display("FAIL bp_timeout: got stalled want idle"); else n_pass++;
    m_flush();
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      next_pair(g, e);
      n_checks++; if (g !== e) $display("FAIL bp_xfer: got cd=%b data=%h want cd=%b data=%h", g[32], g[31:0], e[32], e[31:0]); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit ok, k;
    logic [7:0] c;
    logic [32:0] g, e;
    for (int round = 0; round < 3; round++) begin
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(0, 19))
          0, 1:    c = 8'h0A;
          2:       c = 8'h0C;
          default: c = 8'($urandom_range(8'h20, 8'h7E));
        endcase
        push_char(c, k);
        ok = ok && k;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(k);
      n_checks++; if (!(ok && k)) $display("FAIL random_timeout: got stalled want idle"); else n_pass++;
      m_flush();
      n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        next_pair(g, e);
        n_checks++; if (g !== e) $display("FAIL random_xfer: got cd=%b data=%h want cd=%b data=%h", g[32], g[31:0], e[32], e[31:0]); else n_pass++;
      end
      got_q.delete(); exp_q.delete();
      n_checks++; if (cursor !== 5'(m_cur)) $display("FAIL random_cursor: got %0d want %0d", cursor, m_cur); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok, k;
    int g_cnt;
    logic [32:0] g, e;
    push_string("ABCD", ok);
    g_cnt = 0;
    while (!enableWriting && g_cnt < 200) begin
      @(posedge clk);
      #1 g_cnt++;
    end
    n_checks++; if (enableWriting !== 1'b1) $display("FAIL midrst_strobe: got %b want 1", enableWriting); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (enableWriting !== 1'b0) $display("FAIL midrst_enable_async: got %b want 0", enableWriting); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else n_pass++;
    got_q.delete(); exp_q.delete(); m_buf.delete(); m_cur = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_cmd(8'h01);
    wait_idle(k);
    n_checks++; if (!(ok && k)) $display("FAIL midrst_timeout: got stalled want idle"); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL midrst_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      next_pair(g, e);
      n_checks++; if (g !== e) $display("FAIL midrst_xfer: got cd=%b data=%h want cd=%b data=%h", g[32], g[31:0], e[32], e[31:0]); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
    n_checks++; if (cursor !== 5'(m_cur)) $display("FAIL midrst_cursor: got %0d want %0d", cursor, m_cur); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hello();
    test_line_wrap();
    test_newline();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_text_feeder.md
# lcd_text_feeder

Character-stream front end for the LCD driver. Accepts ASCII bytes through a valid/ready port, buffers them in a small FIFO, packs them MSB-first into 32-bit words, and drives the driver's `data` / `selectCD` / `enableWriting` / `LCD_Available` handshake. It tracks the cursor over a 2x16 display and inserts line-address and clear commands itself. It replaces hand-written test sequencers: producers simply stream text.

## Interface
- `FIFO_DEPTH`, 16: character FIFO entries, power of 2.
- `FLUSH_CYCLES`, 50000: idle cycles after which a partial word is padded and sent.
- `PAD_CHAR`, 8'h20: fill byte for partial words.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_char`  in  8  ASCII byte; 0x0A = newline, 0x0C = clear screen.
- `in_valid`  in  1  `in_char` valid.
- `in_ready`  out  1  FIFO not full.
- `LCD_Available`  in  1  driver idle and able to accept a transfer.
- `data`  out  32  to driver; char0 in [31:24] … char3 in [7:0]; commands use byte [31:24] with [23:0] = 0.
- `selectCD`  out  1  1 = character data, 0 = command.
- `enableWriting`  out  1  one-cycle transfer strobe.
- `cursor`  out  5  current DDRAM position 0..31; line 2 starts at 16.
- `busy`  out  1  FIFO non-empty, partial word held, or transfer in flight.

## Operation
- Push into the FIFO on `in_valid && in_ready`. A push while full is impossible because `in_ready` = 0.
- The collector pops one byte per cycle while the FSM is in COLLECT:
  - A printable byte goes into the next word slot.
  - 0x0A pads the current word, if it is non-empty, with `PAD_CHAR` and sends it. It then sends command 0xC0 if `cursor` < 16, else 0x80.
  - 0x0C discards the partial word and sends command 0x01.
- A word is sent when 4 bytes are collected, or when the flush counter reaches `FLUSH_CYCLES` with 1–3 bytes held. The counter resets on every pop.
- Words are always 4 bytes, so `cursor` is always a multiple of 4 at word start.
- After a word completes:
  - `cursor` += 4.
  - If `cursor` becomes 16, command 0xC0 is sent automatically.
  - If `cursor` becomes 32, command 0x80 is sent and `cursor` becomes 0.
- Commands 0x80 and 0x01 set `cursor` to 0. Command 0xC0 sets it to 16.
- On reset exit, command 0x01 is sent before any character.
- FSM states:
  - INIT: load clear command → ISSUE.
  - COLLECT: gather bytes; on word or command ready → ISSUE.
  - ISSUE: wait for `LCD_Available` = 1; drive `data`/`selectCD` and pulse `enableWriting` for one cycle → WAIT_ACCEPT.
  - WAIT_ACCEPT: wait for `LCD_Available` = 0 → WAIT_DONE.
  - WAIT_DONE: wait for `LCD_Available` = 1; update `cursor`; if an auto/newline command is pending → ISSUE, else → COLLECT.
- One pending-command register holds an address or clear command queued behind a word.

## Timing
- Reset values:
  - `data` = 0, `selectCD` = 1, `enableWriting` = 0.
  - `cursor` = 0, `in_ready` = 1, `busy` = 1 (INIT pending).
  - FSM = INIT, FIFO empty, flush counter 0.
- `data` and `selectCD` are stable from the `enableWriting` cycle until WAIT_DONE exits.
- ISSUE with `LCD_Available` already 1: `enableWriting` is asserted on the next edge.
- The FIFO is not popped outside COLLECT. Pushes continue until full.
- A simultaneous push and pop when full is allowed: `in_ready` is combinational !full, so a pop frees the slot the next cycle.
- Reset mid-transfer: all state is cleared immediately. `enableWriting` drops asynchronously. The clear is re-issued after reset.
- 0x0A on an empty word at `cursor` 0 or 16: no pad word is sent; only the address command is sent.

## Structure
- Package `lcd_pkg`:
  - command constants: `LCD_CMD_CLEAR` = 8'h01, `LCD_CMD_LINE1` = 8'h80, `LCD_CMD_LINE2` = 8'hC0.
  - control codes: `CHR_NL` = 8'h0A, `CHR_FF` = 8'h0C.
  - FSM state enum.
- Sub-module `lcd_char_fifo`: synchronous FIFO, parameter DEPTH, full/empty flags, async reset.

## Test plan
- Reset released, driver model acks every transfer after 3 cycles → first transfer is `data` = 32'h01000000 with `selectCD` = 0. Then `cursor` = 0.
- Push "HELLO WORLD!" → words 0x48454C4C, 0x4F20574F, 0x524C4421 with `selectCD` = 1. Then `cursor` = 12.
- Push 16 characters from `cursor` 0 → 4 words, then auto 0xC0 command; `cursor` = 16. Push 16 more → 4 words, then 0x80 command; `cursor` = 0.
- Push "AB" then 0x0A at `cursor` 0 → word 0x41422020, then command 0xC0; `cursor` = 16.
- Push "X" and go idle, `FLUSH_CYCLES` = 20 → after 20 idle cycles, word 0x58202020 is sent.
- Driver holds `LCD_Available` = 0 for 200 cycles while 20 bytes are pushed → `in_ready` falls after 16 bytes accepted. No byte is lost. Output order is preserved after release.
